// File: rtl/gpio_filter_pkg.sv
// Shared types and constants for the GPIO input filter.
// Optional feature macro: GPIO_FILTER_GLITCH_CNT_EN (per-channel rejected-glitch counters).
package gpio_filter_pkg;

  // Per-channel filter state: settled, or a candidate level is being timed.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_e;

  localparam int DEFAULT_FILTER_WIDTH = 8;
  localparam int GLITCH_CNT_WIDTH     = 8;

endpackage

// File: rtl/gpio_filter_channel.sv
// One GPIO channel: debounce FSM, tick counter, edge strobes and,
// when GPIO_FILTER_GLITCH_CNT_EN is defined, a saturating rejected-glitch counter.
module gpio_filter_channel
  import gpio_filter_pkg::*;
#(
  parameter int FILTER_WIDTH = DEFAULT_FILTER_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps_clk,
  input  logic                        sync_in,
  input  logic [FILTER_WIDTH-1:0]     threshold,
`ifdef GPIO_FILTER_GLITCH_CNT_EN
  input  logic                        glitch_clr,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_count,
`endif
  output logic                        filtered_out,
  output logic                        rise_pulse,
  output logic                        fall_pulse
);

  filt_state_e             state_reg, state_next;
  logic [FILTER_WIDTH-1:0] cnt_reg, cnt_next;
  logic                    filt_reg, filt_next;
  logic                    rise_reg, rise_next;
  logic                    fall_reg, fall_next;
  logic                    commit;
  // One bit wider than the counter so the compare sees cnt+1 without wrap.
  logic [FILTER_WIDTH:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_reg} + {{FILTER_WIDTH{1'b0}}, 1'b1};

  // State, counter, level and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_STABLE;
      cnt_reg   <= '0;
      filt_reg  <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      filt_reg  <= filt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // Next-state logic: a revert always beats a tick; threshold 0 commits straight from STABLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    filt_next  = filt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_STABLE: begin
        if (sync_in != filt_reg) begin
          if (threshold == '0) begin
            commit = 1'b1;
          end else begin
            state_next = ST_PENDING;
            cnt_next   = '0;
          end
        end
      end
      ST_PENDING: begin
        if (sync_in == filt_reg) begin
          state_next = ST_STABLE;
        end else if (ps_clk) begin
          cnt_next = (&cnt_reg) ? cnt_reg : cnt_inc[FILTER_WIDTH-1:0];
          if (cnt_inc >= {1'b0, threshold}) begin
            commit = 1'b1;
          end
        end
      end
      default: state_next = ST_STABLE;
    endcase
    if (commit) begin
      filt_next  = sync_in;
      rise_next  = sync_in;
      fall_next  = ~sync_in;
      state_next = ST_STABLE;
    end
  end

  assign filtered_out = filt_reg;
  assign rise_pulse   = rise_reg;
  assign fall_pulse   = fall_reg;

`ifdef GPIO_FILTER_GLITCH_CNT_EN
  logic                        revert;
  logic [GLITCH_CNT_WIDTH-1:0] glitch_reg;

  assign revert = (state_reg == ST_PENDING) && (sync_in == filt_reg);

  // Rejected-glitch counter: clear has priority, saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_reg <= '0;
    end else if (glitch_clr) begin
      glitch_reg <= '0;
    end else if (revert && !(&glitch_reg)) begin
      glitch_reg <= glitch_reg + 1'b1;
    end
  end

  assign glitch_count = glitch_reg;
`endif

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input filter top: shared input synchroniser feeding CORE_WIDTH filter channels.
// Optional feature macro: GPIO_FILTER_GLITCH_CNT_EN adds glitch_clr / glitch_count.
module gpio_input_filter
  import gpio_filter_pkg::*;
#(
  parameter int CORE_WIDTH   = 4,
  parameter int FILTER_WIDTH = DEFAULT_FILTER_WIDTH,
  parameter int SYNC_STAGES  = 2   // must be >= 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ps_clk,
  input  logic [CORE_WIDTH-1:0]              raw_input,
  input  logic [CORE_WIDTH*FILTER_WIDTH-1:0] filter_conf,
`ifdef GPIO_FILTER_GLITCH_CNT_EN
  input  logic                               glitch_clr,
  output logic [CORE_WIDTH*GLITCH_CNT_WIDTH-1:0] glitch_count,
`endif
  output logic [CORE_WIDTH-1:0]              filtered_out,
  output logic [CORE_WIDTH-1:0]              rise_pulse,
  output logic [CORE_WIDTH-1:0]              fall_pulse
);

  logic [CORE_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [CORE_WIDTH-1:0] sync_last;

  // Synchroniser chain for all pins; stage 0 is the metastability catcher.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= raw_input;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign sync_last = sync_reg[SYNC_STAGES-1];

  for (genvar gi = 0; gi < CORE_WIDTH; gi++) begin : g_ch
    gpio_filter_channel #(
      .FILTER_WIDTH (FILTER_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .ps_clk       (ps_clk),
      .sync_in      (sync_last[gi]),
      .threshold    (filter_conf[FILTER_WIDTH*gi +: FILTER_WIDTH]),
`ifdef GPIO_FILTER_GLITCH_CNT_EN
      .glitch_clr   (glitch_clr),
      .glitch_count (glitch_count[GLITCH_CNT_WIDTH*gi +: GLITCH_CNT_WIDTH]),
`endif
      .filtered_out (filtered_out[gi]),
      .rise_pulse   (rise_pulse[gi]),
      .fall_pulse   (fall_pulse[gi])
    );
  end

endmodule
